transmissor_dados_jogo: RTL

- Downstream consumer of the asteroid/shot coordination FSM.
- On a one-cycle `enviar_dados` pulse, reads NUM_BYTES bytes of game state from a synchronous-read RAM and serialises them LSB-first as 8N1 UART frames on `saida_serial`.
- Then pulses `fim_transmissao_de_dados` for one cycle, so the coordination FSM can leave its wait-for-transmission state.

---
 rtl/transmissor_dados_jogo_pkg.sv | 39 +++
 rtl/transmissor_dados_jogo_if.sv | 10 +
 rtl/transmissor_dados_jogo_tick.sv | 26 ++
 rtl/transmissor_dados_jogo.sv | 135 +++++++++++++
 4 files changed

// File: rtl/transmissor_dados_jogo_pkg.sv
// Shared definitions for the game-state UART transmitter: state codes and line levels.
// The PARIDADE state exists only when TRANSMISSOR_PARIDADE_EN is defined.
package transmissor_pkg;

    localparam logic [3:0] EST_OCIOSO     = 4'd0;
    localparam logic [3:0] EST_LE_MEM     = 4'd1;
    localparam logic [3:0] EST_ESPERA_MEM = 4'd2;
    localparam logic [3:0] EST_CARREGA    = 4'd3;
    localparam logic [3:0] EST_START      = 4'd4;
    localparam logic [3:0] EST_DADOS      = 4'd5;
    localparam logic [3:0] EST_STOP       = 4'd6;
    localparam logic [3:0] EST_FIM        = 4'd7;
    localparam logic [3:0] EST_PARIDADE   = 4'd8;

    typedef enum logic [3:0] {
        StOcioso    = EST_OCIOSO,
        StLeMem     = EST_LE_MEM,
        StEsperaMem = EST_ESPERA_MEM,
        StCarrega   = EST_CARREGA,
        StStart     = EST_START,
        StDados     = EST_DADOS,
        StStop      = EST_STOP,
`ifdef TRANSMISSOR_PARIDADE_EN
        StParidade  = EST_PARIDADE,
`endif
        StFim       = EST_FIM
    } estado_t;

    localparam logic        NIVEL_OCIOSO = 1'b1;
    localparam logic        NIVEL_START  = 1'b0;
    localparam logic        NIVEL_STOP   = 1'b1;
    localparam int unsigned BITS_DADOS   = 8;

    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic paridade_par(input logic [BITS_DADOS-1:0] dado);
        return ^dado;
    endfunction

endpackage

// File: rtl/transmissor_dados_jogo_if.sv
// Synchronous-read RAM port between the transmitter (master) and the game-state RAM (slave).
interface transmissor_dados_jogo_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] endereco_mem;
    logic [7:0]        dado_mem;

    modport master (output endereco_mem, input dado_mem);
    modport slave  (input endereco_mem, output dado_mem);
endinterface

// File: rtl/transmissor_dados_jogo_tick.sv
// Baud-rate tick generator: counts CLKS_POR_BIT clocks per serial bit, with synchronous clear.
module gerador_tick_baud #(
    parameter int unsigned CLKS_POR_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    output logic tick
);
    localparam int unsigned CW = (CLKS_POR_BIT > 2) ? $clog2(CLKS_POR_BIT) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(CLKS_POR_BIT - 1);

    logic [CW-1:0] cnt_clk;

    assign tick = (cnt_clk == ULTIMO);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_clk <= '0;
        end else if (limpa || tick) begin
            cnt_clk <= '0;
        end else begin
            cnt_clk <= cnt_clk + 1'b1;
        end
    end
endmodule

// File: rtl/transmissor_dados_jogo.sv
// Reads NUM_BYTES of game state from RAM and sends them as UART frames, then pulses done.
// Optional even-parity bit per frame with TRANSMISSOR_PARIDADE_EN.
module transmissor_dados_jogo
    import transmissor_pkg::*;
#(
    parameter int unsigned CLKS_POR_BIT = 434,
    parameter int unsigned NUM_BYTES    = 16,
    parameter int unsigned ADDR_W       = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enviar_dados,
    transmissor_dados_jogo_if.master   mem,
    output logic                       saida_serial,
    output logic                       ocupado,
    output logic                       fim_transmissao_de_dados,
    output logic [3:0]                 db_estado
);
    localparam logic [ADDR_W-1:0] ULTIMO_BYTE = ADDR_W'(NUM_BYTES - 1);

    estado_t                 estado;
    logic [ADDR_W-1:0]       cnt_byte;
    logic [2:0]              cnt_bit;
    logic [BITS_DADOS-1:0]   shift;
    logic                    paridade;
    logic                    tick;
    logic                    em_quadro;

    // Baud counter only runs while a frame is on the line, so every bit starts aligned.
    always_comb begin
        em_quadro = 1'b0;
        case (estado)
            StStart, StDados, StStop: em_quadro = 1'b1;
`ifdef TRANSMISSOR_PARIDADE_EN
            StParidade:               em_quadro = 1'b1;
`endif
            default:                  em_quadro = 1'b0;
        endcase
    end

    gerador_tick_baud #(
        .CLKS_POR_BIT(CLKS_POR_BIT)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .limpa(!em_quadro),
        .tick (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= StOcioso;
            cnt_byte <= '0;
            cnt_bit  <= '0;
            shift    <= '0;
            paridade <= 1'b0;
        end else begin
            case (estado)
                StOcioso: begin
                    if (enviar_dados) begin
                        cnt_byte <= '0;
                        estado   <= StLeMem;
                    end
                end
                StLeMem:     estado <= StEsperaMem;
                StEsperaMem: estado <= StCarrega;
                StCarrega: begin
                    shift    <= mem.dado_mem;
                    paridade <= paridade_par(mem.dado_mem);
                    cnt_bit  <= '0;
                    estado   <= StStart;
                end
                StStart: begin
                    if (tick) estado <= StDados;
                end
                StDados: begin
                    if (tick) begin
                        shift <= {1'b0, shift[BITS_DADOS-1:1]};
                        if (cnt_bit == 3'd7) begin
`ifdef TRANSMISSOR_PARIDADE_EN
                            estado <= StParidade;
`else
                            estado <= StStop;
`endif
                        end else begin
                            cnt_bit <= cnt_bit + 3'd1;
                        end
                    end
                end
`ifdef TRANSMISSOR_PARIDADE_EN
                StParidade: begin
                    if (tick) estado <= StStop;
                end
`endif
                StStop: begin
                    if (tick) begin
                        if (cnt_byte == ULTIMO_BYTE) begin
                            estado <= StFim;
                        end else begin
                            cnt_byte <= cnt_byte + 1'b1;
                            estado   <= StLeMem;
                        end
                    end
                end
                StFim:   estado <= StOcioso;
                default: estado <= StOcioso;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    always_comb begin
        saida_serial = NIVEL_OCIOSO;
        case (estado)
            StStart:    saida_serial = NIVEL_START;
            StDados:    saida_serial = shift[0];
`ifdef TRANSMISSOR_PARIDADE_EN
            StParidade: saida_serial = paridade;
`endif
            StStop:     saida_serial = NIVEL_STOP;
            default:    saida_serial = NIVEL_OCIOSO;
        endcase
    end

    assign ocupado                  = (estado != StOcioso);
    assign fim_transmissao_de_dados = (estado == StFim);
    assign db_estado                = estado;
    assign mem.endereco_mem         = cnt_byte;

`ifndef TRANSMISSOR_PARIDADE_EN
    logic paridade_sem_uso;
    assign paridade_sem_uso = paridade;
`endif

endmodule
